// File: rtl/regfile_wb_sched_pkg.sv
// regfile_wb_sched_pkg: shared widths, starvation default and grant encoding for the write-back scheduler
package regfile_wb_sched_pkg;
    localparam int CPU_WIDTH      = 64;
    localparam int REG_ADDRW      = 5;
    localparam int REG_COUNT      = 32;
    localparam int STARVE_MAX_DEF = 4;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_P,
        GNT_L
    } gnt_e;
endpackage

// File: rtl/regfile_wb_sched_scoreboard.sv
// regfile_scoreboard: pending-write vector for long-latency destinations, issue gating and decode hazard lookup
module regfile_scoreboard
    import regfile_wb_sched_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_iss_valid,
    input  logic [REG_ADDRW-1:0] i_iss_rd,
    input  logic                 i_clr_en,
    input  logic [REG_ADDRW-1:0] i_clr_addr,
    input  logic [REG_ADDRW-1:0] i_raddr1,
    input  logic [REG_ADDRW-1:0] i_raddr2,
    input  logic [REG_ADDRW-1:0] i_rd,
    output logic                 o_iss_ready,
    output logic                 o_stall,
    output logic [REG_COUNT-1:0] o_pending
);
    logic [REG_COUNT-1:1] pending_q, pending_d;
    logic                 set_en;

    always_comb begin
        o_pending   = {pending_q, 1'b0};
        o_iss_ready = !o_pending[i_iss_rd];
        o_stall     = o_pending[i_raddr1] || o_pending[i_raddr2] || o_pending[i_rd];
        set_en      = i_iss_valid && o_iss_ready;
        // x0 has no flop, so set/clear of address 0 falls away naturally
        for (int i = 1; i < REG_COUNT; i++)
            pending_d[i] = (pending_q[i] && !(i_clr_en && i_clr_addr == REG_ADDRW'(i)))
                         || (set_en && i_iss_rd == REG_ADDRW'(i));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) pending_q <= '0;
        else       pending_q <= pending_d;
    end
endmodule

// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched: arbitrates the regfile write port between pipeline and long-latency unit, with scoreboard stall
module regfile_wb_sched
    import regfile_wb_sched_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_iss_valid,
    input  logic [REG_ADDRW-1:0] i_iss_rd,
    output logic                 o_iss_ready,
    input  logic                 i_p_valid,
    input  logic [REG_ADDRW-1:0] i_p_addr,
    input  logic [CPU_WIDTH-1:0] i_p_data,
    output logic                 o_p_ready,
    input  logic                 i_l_valid,
    input  logic [REG_ADDRW-1:0] i_l_addr,
    input  logic [CPU_WIDTH-1:0] i_l_data,
    output logic                 o_l_ready,
    output logic                 o_wen,
    output logic [REG_ADDRW-1:0] o_waddr,
    output logic [CPU_WIDTH-1:0] o_wdata,
    input  logic [REG_ADDRW-1:0] i_raddr1,
    input  logic [REG_ADDRW-1:0] i_raddr2,
    input  logic [REG_ADDRW-1:0] i_rd,
    output logic                 o_stall,
    output logic [REG_COUNT-1:0] s_pending
);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starve_q, starve_d;
    logic       p_blk;
    gnt_e       gnt;

    regfile_scoreboard u_sb (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_iss_valid (i_iss_valid),
        .i_iss_rd    (i_iss_rd),
        .i_clr_en    (o_l_ready),
        .i_clr_addr  (i_l_addr),
        .i_raddr1    (i_raddr1),
        .i_raddr2    (i_raddr2),
        .i_rd        (i_rd),
        .o_iss_ready (o_iss_ready),
        .o_stall     (o_stall),
        .o_pending   (s_pending)
    );

    always_comb begin
        // P must not overtake an outstanding L write to the same register
        p_blk     = i_p_valid && s_pending[i_p_addr];
        gnt       = (i_l_valid && (!i_p_valid || p_blk || starve_q == STARVE_LIM)) ? GNT_L
                  : (i_p_valid && !p_blk) ? GNT_P : GNT_NONE;
        o_l_ready = gnt == GNT_L;
        o_p_ready = gnt == GNT_P;
        o_waddr   = o_l_ready ? i_l_addr : o_p_ready ? i_p_addr : '0;
        o_wdata   = o_l_ready ? i_l_data : o_p_ready ? i_p_data : '0;
        o_wen     = gnt != GNT_NONE && o_waddr != '0;
        starve_d  = o_l_ready ? 4'd0
                  : (i_l_valid && starve_q != STARVE_LIM) ? starve_q + 4'd1 : starve_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) starve_q <= '0;
        else       starve_q <= starve_d;
    end
endmodule

// File: tb/tb_regfile_wb_sched.sv
// tb_regfile_wb_sched: directed scoreboard bench for the write-back scheduler
module tb_regfile_wb_sched;
    import regfile_wb_sched_pkg::*;

    typedef struct {
        logic                 wen;
        logic [REG_ADDRW-1:0] addr;
        logic [CPU_WIDTH-1:0] data;
    } wb_t;

    logic                 clk = 0, rst;
    logic                 iss_valid, iss_ready, p_valid, p_ready, l_valid, l_ready, wen, stall;
    logic [REG_ADDRW-1:0] iss_rd, p_addr, l_addr, waddr, raddr1, raddr2, rd;
    logic [CPU_WIDTH-1:0] p_data, l_data, wdata;
    logic [REG_COUNT-1:0] pending;

    wb_t                  exp_q[$];
    logic [CPU_WIDTH-1:0] rf[REG_COUNT];
    int                   checks = 0, failures = 0;

    always #5 clk = ~clk;

    regfile_wb_sched #(.STARVE_MAX(4)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_iss_valid(iss_valid), .i_iss_rd(iss_rd), .o_iss_ready(iss_ready),
        .i_p_valid(p_valid), .i_p_addr(p_addr), .i_p_data(p_data), .o_p_ready(p_ready),
        .i_l_valid(l_valid), .i_l_addr(l_addr), .i_l_data(l_data), .o_l_ready(l_ready),
        .o_wen(wen), .o_waddr(waddr), .o_wdata(wdata),
        .i_raddr1(raddr1), .i_raddr2(raddr2), .i_rd(rd),
        .o_stall(stall), .s_pending(pending)
    );

    task automatic chk(input string tag, input logic [CPU_WIDTH-1:0] obs, input logic [CPU_WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        iss_valid = 0; iss_rd = 0; p_valid = 0; p_addr = 0; p_data = 0;
        l_valid = 0; l_addr = 0; l_data = 0; raddr1 = 0; raddr2 = 0; rd = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic w, input logic [REG_ADDRW-1:0] a, input logic [CPU_WIDTH-1:0] d);
        wb_t e;
        e.wen = w; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    // settle, check grants, pop the expected write-port beat and compare
    task automatic step(input string tag, input logic ep, input logic el);
        wb_t e;
        #1;
        chk({tag, "_p_ready"}, 64'(p_ready), 64'(ep));
        chk({tag, "_l_ready"}, 64'(l_ready), 64'(el));
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_empty"}, 64'(1), 64'(0));
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_wen"},   64'(wen),   64'(e.wen));
            chk({tag, "_waddr"}, 64'(waddr), 64'(e.addr));
            chk({tag, "_wdata"}, wdata,      e.data);
        end
        if (wen) rf[waddr] = wdata;
    endtask

    initial begin
        logic lw;
        idle();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        #1;
        chk("rst_pending",   64'(pending),   64'(0));
        chk("rst_iss_ready", 64'(iss_ready), 64'(1));
        chk("rst_stall",     64'(stall),     64'(0));
        chk("rst_wen",       64'(wen),       64'(0));
        chk("rst_p_ready",   64'(p_ready),   64'(0));
        chk("rst_l_ready",   64'(l_ready),   64'(0));

        // 1: pipeline-only write
        p_valid = 1; p_addr = 5; p_data = 64'h1234;
        push(1, 5, 64'h1234);
        step("t1", 1, 0);
        chk("t1_starve", 64'(dut.starve_q), 64'(0));
        tick();
        idle();

        // 2: issue rd 7, stall on it, retire through L
        iss_valid = 1; iss_rd = 7;
        #1 chk("t2_iss_ready", 64'(iss_ready), 64'(1));
        tick();
        iss_valid = 0; raddr1 = 7;
        #1 chk("t2_stall_set", 64'(stall), 64'(1));
        chk("t2_pend_set", 64'(pending[7]), 64'(1));
        l_valid = 1; l_addr = 7; l_data = 64'hAA;
        push(1, 7, 64'hAA);
        step("t2", 0, 1);
        chk("t2_stall_same_cycle", 64'(stall), 64'(1));
        tick();
        l_valid = 0;
        #1 chk("t2_stall_drop", 64'(stall), 64'(0));
        chk("t2_pend_clr", 64'(pending[7]), 64'(0));
        idle();

        // 3: starvation protection, L forced in every fifth cycle
        p_valid = 1; p_addr = 1; p_data = 64'h1111;
        l_valid = 1; l_addr = 2; l_data = 64'h2222;
        for (int k = 0; k < 10; k++) begin
            lw = (k % 5 == 4);
            push(1, lw ? 5'd2 : 5'd1, lw ? 64'h2222 : 64'h1111);
            step("t3", !lw, lw);
            tick();
        end
        #1 chk("t3_starve_cleared", 64'(dut.starve_q), 64'(0));
        idle();

        // 4: WAW ordering on x9
        iss_valid = 1; iss_rd = 9;
        tick();
        iss_valid = 0;
        p_valid = 1; p_addr = 9; p_data = 64'hB0B0;
        l_valid = 1; l_addr = 9; l_data = 64'hA0A0;
        push(1, 9, 64'hA0A0);
        step("t4_l", 0, 1);
        tick();
        l_valid = 0;
        push(1, 9, 64'hB0B0);
        step("t4_p", 1, 0);
        tick();
        idle();
        chk("t4_rf9", rf[9], 64'hB0B0);

        // 5: x0 issue and write handshake without effect
        iss_valid = 1; iss_rd = 0;
        p_valid = 1; p_addr = 0; p_data = 64'h5555;
        push(0, 0, 64'h5555);
        step("t5", 1, 0);
        chk("t5_iss_ready", 64'(iss_ready), 64'(1));
        tick();
        idle();
        #1 chk("t5_pending", 64'(pending), 64'(0));

        // 6: issue blocked on pending rd, then mid-operation reset
        iss_valid = 1; iss_rd = 3;
        tick();
        push(0, 0, 0);
        step("t6_idle", 0, 0);
        chk("t6_iss_blocked", 64'(iss_ready), 64'(0));
        chk("t6_pending", 64'(pending), 64'(32'h8));
        iss_valid = 0;
        p_valid = 1; p_addr = 1; p_data = 64'h0101;
        l_valid = 1; l_addr = 2; l_data = 64'h0202;
        push(1, 1, 64'h0101);
        step("t6_a", 1, 0);
        tick();
        push(1, 1, 64'h0101);
        step("t6_b", 1, 0);
        tick();
        rst = 1;
        push(1, 1, 64'h0101);
        step("t6_rst", 1, 0);
        tick();
        rst = 0;
        idle();
        iss_rd = 3;
        #1 chk("t6_rst_pending", 64'(pending), 64'(0));
        chk("t6_rst_iss_ready", 64'(iss_ready), 64'(1));
        chk("t6_rst_starve", 64'(dut.starve_q), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
